// File: rtl/tick_pkg.sv
// Shared types, defaults and helpers for the multi-channel tick generator.
// Imported by tick_channel and tick_gen_multi.
package tick_pkg;

    typedef enum logic {
        TICK_PULSE  = 1'b0,
        TICK_SQUARE = 1'b1
    } tick_mode_e;

    localparam int TICK_CNT_W_DEF   = 24;
    localparam int TICK_DEFAULT_DIV = 10_000_000;

    // Channel-select width; a single channel still gets a 1-bit select port.
    function automatic int tick_ch_w(input int n_ch);
        return (n_ch > 1) ? $clog2(n_ch) : 1;
    endfunction

endpackage

// File: rtl/tick_channel.sv
// One divider channel: counter, active/shadow divisor, pending flag and output register.
// New divisors wait in the shadow register until a terminal count, a sync or a disable.
module tick_channel
    import tick_pkg::*;
#(
    parameter int CNT_W       = TICK_CNT_W_DEF,
    parameter int DEFAULT_DIV = TICK_DEFAULT_DIV
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  tick_mode_e       mode,
    input  logic             sync,
    input  logic             load,
    input  logic [CNT_W-1:0] load_data,
    output logic             pend,
    output logic             q
);

    localparam logic [CNT_W-1:0] DIV_RST = CNT_W'(DEFAULT_DIV);

    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [CNT_W-1:0] div_reg, div_next;
    logic [CNT_W-1:0] shd_reg, shd_next;
    logic             pend_reg, pend_next;
    logic             q_reg, q_next;
    logic             en_d_reg;
    tick_mode_e       mode_d_reg;
    logic             tc;

    // A zero divisor never reaches terminal count; div == 1 hits it every cycle.
    assign tc = (div_reg != '0) && (cnt_reg == (div_reg - CNT_W'(1)));

    always_comb begin
        cnt_next  = cnt_reg;
        div_next  = div_reg;
        shd_next  = shd_reg;
        pend_next = pend_reg;
        q_next    = q_reg;

        if (sync || !en) begin
            cnt_next = '0;
            q_next   = 1'b0;
            if (pend_reg) begin
                div_next  = shd_reg;
                pend_next = 1'b0;
            end
        end else if (!en_d_reg || (div_reg == '0)) begin
            // First enabled edge restarts the phase so the first tick lands at cycle div.
            cnt_next = '0;
            q_next   = 1'b0;
        end else begin
            cnt_next = tc ? '0 : cnt_reg + CNT_W'(1);
            if (tc && pend_reg) begin
                div_next  = shd_reg;
                pend_next = 1'b0;
            end
            if (mode != mode_d_reg) begin
                q_next = 1'b0;
            end else if (mode == TICK_PULSE) begin
                q_next = tc;
            end else begin
                q_next = q_reg ^ tc;
            end
        end

        // Loads only arrive while pend is clear, so they never race an apply.
        if (load) begin
            shd_next  = load_data;
            pend_next = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_reg    <= '0;
            div_reg    <= DIV_RST;
            shd_reg    <= DIV_RST;
            pend_reg   <= 1'b0;
            q_reg      <= 1'b0;
            en_d_reg   <= 1'b0;
            mode_d_reg <= mode;
        end else begin
            cnt_reg    <= cnt_next;
            div_reg    <= div_next;
            shd_reg    <= shd_next;
            pend_reg   <= pend_next;
            q_reg      <= q_next;
            en_d_reg   <= en;
            mode_d_reg <= mode;
        end
    end

    assign pend = pend_reg;
    assign q    = q_reg;

endmodule

// File: rtl/tick_gen_multi.sv
// Multi-channel programmable tick / square-wave generator with a valid/ready
// divisor write port; writes to channels beyond N_CH are accepted and dropped.
module tick_gen_multi
    import tick_pkg::*;
#(
    parameter int  CNT_W       = TICK_CNT_W_DEF,
    parameter int  N_CH        = 4,
    parameter int  DEFAULT_DIV = TICK_DEFAULT_DIV,
    localparam int CH_W        = tick_ch_w(N_CH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_CH-1:0]  en,
    input  logic [N_CH-1:0]  mode,
    input  logic             sync,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [CH_W-1:0]  cfg_ch,
    input  logic [CNT_W-1:0] cfg_div,
    output logic [N_CH-1:0]  tick_out
);

    logic [N_CH-1:0] ch_sel;
    logic [N_CH-1:0] ch_pend;
    logic [N_CH-1:0] ch_load;
    logic            cfg_accept;

    genvar gi;
    generate
        for (gi = 0; gi < N_CH; gi++) begin : g_ch
            assign ch_sel[gi]  = (cfg_ch == CH_W'(gi));
            assign ch_load[gi] = cfg_accept && ch_sel[gi];

            tick_channel #(
                .CNT_W       (CNT_W),
                .DEFAULT_DIV (DEFAULT_DIV)
            ) u_ch (
                .clk       (clk),
                .rst_n     (rst_n),
                .en        (en[gi]),
                .mode      (tick_mode_e'(mode[gi])),
                .sync      (sync),
                .load      (ch_load[gi]),
                .load_data (cfg_div),
                .pend      (ch_pend[gi]),
                .q         (tick_out[gi])
            );
        end
    endgenerate

    // Out-of-range selects match no channel, so they read as ready and load nothing.
    assign cfg_ready  = ~|(ch_sel & ch_pend);
    assign cfg_accept = cfg_valid && cfg_ready;

endmodule

// File: doc/tick_gen_multi.md
# tick_gen_multi

Parametrised, multi-channel successor to the single fixed 100 MHz → 5 Hz divider. Each of N_CH channels divides `clk` by its own runtime-programmable divisor and emits either a one-cycle tick or a 50 % square wave. Divisors change through a valid/ready config port and take effect glitch-free at the next terminal count. It feeds the servo PWM frame timer, SPI poll strobes and LED blink rates from one block.

## Interface
- `CNT_W`, 24: divisor and counter width.
- `N_CH`, 4: number of channels, 1..16.
- `DEFAULT_DIV`, 10_000_000: divisor loaded into every channel at reset. That gives 10 Hz ticks at 100 MHz.
- `clk  in  1`: system clock. This block has one clock.
- `rst_n  in  1`: synchronous, active-low reset.
- `en  in  N_CH`: per-channel run enable.
- `mode  in  N_CH`: per-channel output mode. 0 = PULSE, 1 = SQUARE. Sampled every cycle.
- `sync  in  1`: one-cycle phase-align strobe for all channels.
- `cfg_valid  in  1`: divisor write request.
- `cfg_ready  out  1`: the write can be accepted.
- `cfg_ch  in  $clog2(N_CH)` (min 1): target channel.
- `cfg_div  in  CNT_W`: new divisor.
- `tick_out  out  N_CH`: registered channel outputs.

## Operation
- Per channel: counter `cnt`, active divisor `div`, shadow divisor `shd`, flag `pend`, output register `q`.
- While `en[i]` is 1 and `div >= 2`:
  - `cnt` counts 0..div-1 and wraps to 0.
  - The terminal count (TC) is the cycle where `cnt == div-1`.
- PULSE mode: `q` is 1 for exactly the cycle after each TC, else 0. The period is exactly `div` cycles.
- SQUARE mode: `q` toggles on every TC. The period is `2*div` cycles.
- When `mode[i]` changes, `q` is cleared to 0 and `cnt` continues counting.
- `div == 1`: PULSE holds `q` = 1 continuously; SQUARE toggles every cycle.
- `div == 0`: the channel is stopped. `cnt` is held at 0 and `q` is 0.
- `en[i]` = 0: `cnt` is forced to 0 and `q` to 0.
  - If `pend` is set while disabled, `shd` is copied to `div` immediately and `pend` is cleared.
- Config handshake:
  - `cfg_ready = !pend[cfg_ch]`. This is combinational on `cfg_ch`.
  - A transfer happens on `cfg_valid && cfg_ready`. It writes `shd[cfg_ch] <= cfg_div` and sets `pend`.
  - `cfg_ch >= N_CH` is accepted and discarded, with no state change.
- Apply rule: at a TC where `pend` was already set at the start of the cycle, `div <= shd`, `pend <= 0` and `cnt <= 0`. The period that just ended used the old divisor.
- Simultaneous transfer and TC on the same channel: the current TC uses the old divisor. The new value applies at the following TC.
- `sync` = 1, which has priority over everything except reset:
  - all `cnt <= 0` and all `q <= 0`;
  - all pending shadows are applied immediately and `pend` is cleared;
  - a config transfer in the same cycle is accepted and stays pending.
- Reset (`rst_n` = 0, sampled on `clk`): `cnt` = 0, `div` = `shd` = DEFAULT_DIV, `pend` = 0, `tick_out` = 0, `cfg_ready` = 1.
  - Reset mid-period discards the count and any pending value.

## Timing
- `en[i]` sampled 1 at edge 0, with `cnt` = 0 after that edge: the first TC is at cycle div-1 and `tick_out[i]` is high in cycle `div`. Each later pulse follows every `div` cycles.
- Output latency from TC to `tick_out` is 1 cycle.
- `cfg_ready` low-to-high: in the cycle after the applying TC.
- `sync` at edge k: all counters are 0 after edge k. First ticks are aligned across channels with equal `div`.
- No combinational path from `en`/`mode`/`sync` to `tick_out`.

## Structure
- Package `tick_pkg` holds:
  - `typedef enum logic {TICK_PULSE, TICK_SQUARE} tick_mode_e`;
  - localparam `TICK_CNT_W_DEF = 24`.
- Sub-module `tick_channel` holds one counter, `div`, `shd`, `pend` and `q`. It takes en, mode, sync, load strobe and load data.
- The top has:
  - a generate loop over `N_CH`;
  - the `cfg_ch` decode;
  - the `cfg_ready` mux.

## Test plan
All scenarios use `N_CH` = 4, `CNT_W` = 8, `DEFAULT_DIV` = 10.
- Reset then `en` = 4'b0001 in PULSE: `tick_out[0]` is high in cycles 10, 20, 30; the other bits stay 0.
- Ch1 in SQUARE with div 10: `tick_out[1]` is high for 10 cycles then low for 10. Write `cfg_div` = 3 mid-period: the current period completes at 10, then half-periods are 3.
- Write div 5 to ch0 on its TC cycle: the next period is still 10, then 5. A second write while `pend` is set sees `cfg_ready` = 0 and no transfer.
- Ch0 div 4, ch2 div 6, both enabled. Assert `sync` at an arbitrary cycle k: both pulse first at k+4 and k+6 respectively, then at every LCM multiple of 12 together.
- Write `div` = 0 to ch3, then `div` = 1: with 0 the output is stuck at 0; with 1 in PULSE the output is stuck at 1.
- Pull `rst_n` low for 1 cycle mid-count with a pending write: `tick_out` = 0, `cfg_ready` = 1, and the next pulse comes 10 cycles after re-enable with `div` = 10.
